// File: rtl/cache_arb_pkg.sv
// Shared definitions for the cache bus arbiter: FSM encoding, default core
// count and the owner-index width helper.
package cache_arb_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE    = 2'd0,
        ARB_GRANT   = 2'd1,
        ARB_RELEASE = 2'd2
    } arb_state_e;

    localparam int DEFAULT_N_CORES = 4;

    function automatic int owner_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set request bit at or above ptr,
// wrapping around through bit 0.
module rr_pick #(
    parameter int N = 4,
    parameter int W = 2
) (
    input  logic [N-1:0] req,
    input  logic [W-1:0] ptr,
    output logic         valid,
    output logic [W-1:0] idx
);

    logic [2*N-1:0] dbl;
    logic [N-1:0]   rot;
    logic [W:0]     sum;

    // Rotating through a doubled vector puts req[(ptr+k) mod N] at rot[k].
    assign dbl   = {req, req} >> ptr;
    assign rot   = dbl[N-1:0];
    assign valid = |req;

    always_comb begin
        idx = '0;
        sum = '0;
        for (int k = N - 1; k >= 0; k--) begin
            if (rot[k]) begin
                sum = {1'b0, ptr} + (W+1)'(k);
                idx = (sum >= (W+1)'(N)) ? W'(sum - (W+1)'(N)) : sum[W-1:0];
            end
        end
    end

endmodule

// File: rtl/cache_bus_arbiter.sv
// Round-robin owner arbitration of the shared snoop/memory bus with a one
// cycle dead gap between owners. Define CACHE_ARB_TIMEOUT_EN for the hold limit.
module cache_bus_arbiter
    import cache_arb_pkg::*;
#(
    parameter int N_CORES  = DEFAULT_N_CORES,
    parameter int MAX_HOLD = 16
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic [N_CORES-1:0]               req,
    input  logic [N_CORES-1:0]               done,
    output logic [N_CORES-1:0]               gnt,
    output logic [owner_width(N_CORES)-1:0]  owner,
    output logic                             bus_busy,
    output logic                             timeout_err,
    output logic [1:0]                       dbg_state
);

    localparam int OW = owner_width(N_CORES);

    localparam logic [1:0] IDLE    = ARB_IDLE;
    localparam logic [1:0] GRANT   = ARB_GRANT;
    localparam logic [1:0] RELEASE = ARB_RELEASE;

    // Handshake: req is a level held for the whole transaction; the owner
    // ends it with a one-cycle done pulse or by dropping req. Bits of
    // non-owners are never looked at while a grant is held.

    logic [1:0]         state_q, state_d;
    logic [N_CORES-1:0] gnt_q, gnt_d;
    logic [OW-1:0]      owner_q, owner_d;
    logic [OW-1:0]      ptr_q, ptr_d;
    logic               busy_q, busy_d;
    logic               tmo_q, tmo_d;

    logic               pick_valid;
    logic [OW-1:0]      pick_idx;
    logic               release_evt;
    logic               hold_expired;

    rr_pick #(
        .N (N_CORES),
        .W (OW)
    ) u_pick (
        .req   (req),
        .ptr   (ptr_q),
        .valid (pick_valid),
        .idx   (pick_idx)
    );

    assign release_evt = done[owner_q] | ~req[owner_q];

`ifdef CACHE_ARB_TIMEOUT_EN
    localparam int HOLD_W = $clog2(MAX_HOLD + 1);

    logic [HOLD_W-1:0] hold_q, hold_d;

    // The last allowed GRANT cycle is the one where the count reads MAX_HOLD-1.
    assign hold_expired = (hold_q == HOLD_W'(MAX_HOLD - 1));

    always_comb begin
        hold_d = hold_q;
        if (state_q == GRANT) begin
            hold_d = hold_q + HOLD_W'(1);
        end else if (pick_valid) begin
            hold_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_q <= '0;
        end else begin
            hold_q <= hold_d;
        end
    end
`else
    assign hold_expired = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        owner_d = owner_q;
        ptr_d   = ptr_q;
        busy_d  = busy_q;
        tmo_d   = 1'b0;
        case (state_q)
            GRANT: begin
                if (release_evt || hold_expired) begin
                    state_d = RELEASE;
                    gnt_d   = '0;
                    busy_d  = 1'b0;
                    tmo_d   = ~release_evt;
                end
            end
            default: begin
                // IDLE and RELEASE share the same pick.
                if (pick_valid) begin
                    state_d = GRANT;
                    gnt_d   = {{(N_CORES-1){1'b0}}, 1'b1} << pick_idx;
                    owner_d = pick_idx;
                    ptr_d   = (pick_idx == OW'(N_CORES - 1)) ? '0 : pick_idx + OW'(1);
                    busy_d  = 1'b1;
                end else begin
                    state_d = IDLE;
                    gnt_d   = '0;
                    busy_d  = 1'b0;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            gnt_q   <= '0;
            owner_q <= '0;
            ptr_q   <= '0;
            busy_q  <= 1'b0;
            tmo_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            owner_q <= owner_d;
            ptr_q   <= ptr_d;
            busy_q  <= busy_d;
            tmo_q   <= tmo_d;
        end
    end

    assign gnt       = gnt_q;
    assign owner     = owner_q;
    assign bus_busy  = busy_q;
    assign dbg_state = state_q;

`ifdef CACHE_ARB_TIMEOUT_EN
    assign timeout_err = tmo_q;
`else
    assign timeout_err = 1'b0;
`endif

endmodule
